// File: rtl/speculative_branch_predictor.sv
// speculative_branch_predictor
// This is a branch predictor built from a table of 2-bit saturating counters.
// It can index the table in three ways: bimodal, gshare or gselect.
// Each accepted prediction pushes its {index, prediction, history} into an
// in-flight FIFO and speculatively shifts the global history register.
// Branches resolve in program order. Each resolve trains one counter.
// On a mispredict, the history is rebuilt from the entry's snapshot and all
// younger entries are discarded.
// Optional feature macro: BP_STATS_EN (prediction/mispredict counters).
module speculative_branch_predictor #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int INDEX_BITS    = 8,
  parameter int HIST_BITS     = 8,
  parameter int MODE          = 1,
  parameter int CTR_INIT      = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_Fetch_valid,
  input  logic [ADDRESS_WIDTH-1:0] i_Fetch_pc,
  output logic                     o_Pred_taken,
  output logic                     o_Full,
  input  logic                     i_Resolve_valid,
  input  logic                     i_Resolve_taken,
  output logic                     o_Mispredict,
  output logic [31:0]              o_Stat_predictions,
  output logic [31:0]              o_Stat_mispredicts
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int G_SEL   = (HIST_BITS < INDEX_BITS / 2) ? HIST_BITS : INDEX_BITS / 2;
  localparam logic [1:0]       CTR_RST = 2'(CTR_INIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // Counter table and global history
  logic [1:0]            ctr_reg [ENTRIES];
  logic [HIST_BITS-1:0]  ghr_reg;
  logic [HIST_BITS-1:0]  ghr_next;

  // In-flight FIFO storage and bookkeeping
  logic [INDEX_BITS-1:0] fifo_idx_reg  [FIFO_DEPTH];
  logic                  fifo_pred_reg [FIFO_DEPTH];
  logic [HIST_BITS-1:0]  fifo_ghr_reg  [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [CNT_W-1:0]      count_reg;

  logic [INDEX_BITS-1:0] pc_idx;
  logic [INDEX_BITS-1:0] fetch_idx;
  logic                  pred;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  mispredict_now;
  logic                  mispredict_reg;
  logic [INDEX_BITS-1:0] head_idx;
  logic                  head_pred;
  logic [HIST_BITS-1:0]  head_ghr;
  logic [1:0]            head_ctr;
  logic [1:0]            trained_ctr;

  // Only the low PC bits address the table; the rest are deliberately ignored.
  logic unused_pc_high;
  assign unused_pc_high = ^i_Fetch_pc[ADDRESS_WIDTH-1:INDEX_BITS];

  assign pc_idx = i_Fetch_pc[INDEX_BITS-1:0];

  // Table index selection for the configured predictor flavour
  generate
    if (MODE == 0) begin : g_bimodal
      assign fetch_idx = pc_idx;
    end else if (MODE == 2) begin : g_gselect
      // Top PC bits are replaced by history bits in the concatenation.
      logic unused_sel_bits;
      assign unused_sel_bits = ^pc_idx[INDEX_BITS-1:INDEX_BITS-G_SEL];
      assign fetch_idx = {ghr_reg[G_SEL-1:0], pc_idx[INDEX_BITS-G_SEL-1:0]};
    end else begin : g_gshare
      assign fetch_idx = pc_idx ^ INDEX_BITS'(ghr_reg);
    end
  endgenerate

  assign pred         = ctr_reg[fetch_idx][1];
  assign o_Pred_taken = pred;

  assign full   = (count_reg == CNT_FULL);
  assign empty  = (count_reg == '0);
  assign o_Full = full;

  assign head_idx  = fifo_idx_reg[rd_ptr_reg];
  assign head_pred = fifo_pred_reg[rd_ptr_reg];
  assign head_ghr  = fifo_ghr_reg[rd_ptr_reg];
  assign head_ctr  = ctr_reg[head_idx];

  assign pop            = i_Resolve_valid & ~empty;
  assign mispredict_now = pop & (head_pred != i_Resolve_taken);
  // A mispredict squashes the wrong-path fetch of the same cycle.
  assign push           = i_Fetch_valid & ~full & ~mispredict_now;

  // Saturating counter training for the resolving entry
  always_comb begin
    trained_ctr = head_ctr;
    if (i_Resolve_taken) begin
      if (head_ctr != 2'd3) trained_ctr = head_ctr + 2'd1;
    end else begin
      if (head_ctr != 2'd0) trained_ctr = head_ctr - 2'd1;
    end
  end

  // Counter table: reset to the initial value, train the popped entry's counter
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_reg[i] <= CTR_RST;
      end
    end else if (pop) begin
      ctr_reg[head_idx] <= trained_ctr;
    end
  end

  // Next history: the checkpoint restore wins over the speculative shift
  always_comb begin
    ghr_next = ghr_reg;
    if (mispredict_now) begin
      ghr_next = {head_ghr[HIST_BITS-2:0], i_Resolve_taken};
    end else if (push) begin
      ghr_next = {ghr_reg[HIST_BITS-2:0], pred};
    end
  end

  // Global history register
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      ghr_reg <= '0;
    end else begin
      ghr_reg <= ghr_next;
    end
  end

  // FIFO pointers and occupancy; a mispredict empties the queue outright
  always_ff @(posedge i_Clk) begin
    if (i_Reset || (mispredict_now && !i_Reset)) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO payload; the slot contents only matter while they are counted as occupied
  always_ff @(posedge i_Clk) begin
    if (push) begin
      fifo_idx_reg[wr_ptr_reg]  <= fetch_idx;
      fifo_pred_reg[wr_ptr_reg] <= pred;
      fifo_ghr_reg[wr_ptr_reg]  <= ghr_reg;
    end
  end

  // One-cycle mispredict pulse for the front end
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      mispredict_reg <= 1'b0;
    end else begin
      mispredict_reg <= mispredict_now;
    end
  end

  assign o_Mispredict = mispredict_reg;

`ifdef BP_STATS_EN
  logic [31:0] stat_pred_reg;
  logic [31:0] stat_misp_reg;

  // Saturating statistics counters
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      stat_pred_reg <= '0;
      stat_misp_reg <= '0;
    end else begin
      if (push && stat_pred_reg != 32'hFFFF_FFFF) stat_pred_reg <= stat_pred_reg + 32'd1;
      if (mispredict_now && stat_misp_reg != 32'hFFFF_FFFF) stat_misp_reg <= stat_misp_reg + 32'd1;
    end
  end

  assign o_Stat_predictions = stat_pred_reg;
  assign o_Stat_mispredicts = stat_misp_reg;
`else
  assign o_Stat_predictions = 32'd0;
  assign o_Stat_mispredicts = 32'd0;
`endif

endmodule
